// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: empty/occupancy tracking, memory read
// addressing, Gray read pointer export, and a first-word-fall-through output register.
module fifo_rd_ctrl #(
  parameter int ADDR_WD = 3,
  parameter int DATA_WD = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [ADDR_WD:0]   RD_SYNC_WPTR,
  input  logic [DATA_WD-1:0] RD_DATA_MEM,
  input  logic               DOUT_READY,
  output logic [ADDR_WD-1:0] RD_ADDR,
  output logic [ADDR_WD:0]   RD_GRAY_PTR,
  output logic               RD_EMPTY,
  output logic [ADDR_WD:0]   RD_LEVEL,
  output logic [DATA_WD-1:0] DOUT,
  output logic               DOUT_VALID
);

  function automatic logic [ADDR_WD:0] bin2gray(input logic [ADDR_WD:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_WD:0] gray2bin(input logic [ADDR_WD:0] g);
    logic [ADDR_WD:0] b;
    b[ADDR_WD] = g[ADDR_WD];
    for (int i = ADDR_WD - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WD:0] rbin;
  logic [ADDR_WD:0] rnext;
  logic [ADDR_WD:0] wbin;
  logic             pop;

  // Never pop while empty; refill DOUT when it is free or being consumed this cycle.
  assign pop   = !RD_EMPTY && (!DOUT_VALID || DOUT_READY);
  assign rnext = rbin + {{ADDR_WD{1'b0}}, pop};
  assign wbin  = gray2bin(RD_SYNC_WPTR);

  assign RD_ADDR = rbin[ADDR_WD-1:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rbin        <= '0;
      RD_GRAY_PTR <= '0;
      RD_EMPTY    <= 1'b1;
      RD_LEVEL    <= '0;
      DOUT        <= '0;
      DOUT_VALID  <= 1'b0;
    end else begin
      rbin        <= rnext;
      RD_GRAY_PTR <= bin2gray(rnext);
      RD_EMPTY    <= (bin2gray(rnext) == RD_SYNC_WPTR);
      RD_LEVEL    <= wbin - rnext;
      if (pop) begin
        DOUT       <= RD_DATA_MEM;
        DOUT_VALID <= 1'b1;
      end else if (DOUT_READY) begin
        DOUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a behavioural writer fills a memory model and
// publishes the Gray write pointer; a negedge monitor checks control and data outputs.
module tb_fifo_rd_ctrl;

  logic       CLK;
  logic       RST;
  logic [3:0] RD_SYNC_WPTR;
  logic [7:0] RD_DATA_MEM;
  logic       DOUT_READY;
  logic [2:0] RD_ADDR;
  logic [3:0] RD_GRAY_PTR;
  logic       RD_EMPTY;
  logic [3:0] RD_LEVEL;
  logic [7:0] DOUT;
  logic       DOUT_VALID;

  fifo_rd_ctrl #(.ADDR_WD(3), .DATA_WD(8)) dut (
    .CLK(CLK), .RST(RST), .RD_SYNC_WPTR(RD_SYNC_WPTR), .RD_DATA_MEM(RD_DATA_MEM),
    .DOUT_READY(DOUT_READY), .RD_ADDR(RD_ADDR), .RD_GRAY_PTR(RD_GRAY_PTR),
    .RD_EMPTY(RD_EMPTY), .RD_LEVEL(RD_LEVEL), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] mem [8];
  assign RD_DATA_MEM = mem[RD_ADDR];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: words published by the writer and words taken from memory.
  int         wcnt = 0;
  int         r_cnt = 0;
  bit         m_valid = 0;
  bit         m_empty = 1;
  int         m_level = 0;
  logic [7:0] exp_q[$];
  logic [3:0] prev_gray;
  bit         have_prev = 0;

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wcnt % 8] = d;
    exp_q.push_back(d);
    wcnt++;
    RD_SYNC_WPTR = gray4(wcnt);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      r_cnt = 0; m_valid = 0; m_empty = 1; m_level = 0; have_prev = 0;
    end else begin
      check("empty", RD_EMPTY, m_empty);
      check("level", RD_LEVEL, m_level);
      check("dout_valid", DOUT_VALID, m_valid);
      check("rd_addr", RD_ADDR, r_cnt % 8);
      check("gray_ptr", RD_GRAY_PTR, gray4(r_cnt));
      if (have_prev) check("gray_one_bit", ($countones(prev_gray ^ RD_GRAY_PTR) <= 1), 1);
      prev_gray = RD_GRAY_PTR;
      have_prev = 1;
      if (DOUT_VALID && DOUT_READY) begin
        if (exp_q.size() == 0) check("dout_unexpected", 1, 0);
        else check("dout", DOUT, exp_q.pop_front());
      end
      if (!m_empty && (!m_valid || DOUT_READY)) begin
        r_cnt++;
        m_valid = 1;
      end else if (DOUT_READY) begin
        m_valid = 0;
      end
      m_level = wcnt - r_cnt;
      m_empty = (m_level == 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int k;
    DOUT_READY = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < 100) begin
      cycles(1);
      k++;
    end
    check("drain_timeout", (k < 100), 1);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RST = 1'b0;
    wcnt = 0;
    RD_SYNC_WPTR = 4'd0;
    exp_q.delete();
    #1;
    check("rst_empty", RD_EMPTY, 1);
    check("rst_valid", DOUT_VALID, 0);
    check("rst_level", RD_LEVEL, 0);
    check("rst_gray", RD_GRAY_PTR, 0);
    check("rst_addr", RD_ADDR, 0);
    check("rst_dout", DOUT, 0);
    cycles(2);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    cycles(1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    RST = 1'b0;
    RD_SYNC_WPTR = 4'd0;
    DOUT_READY = 1'b0;
    do_reset();
    cycles(3);

    // single word
    DOUT_READY = 1'b1;
    write_word(8'hA5);
    cycles(5);

    // backpressure with three queued words
    DOUT_READY = 1'b0;
    write_word(8'h11); write_word(8'h22); write_word(8'h33);
    cycles(6);
    DOUT_READY = 1'b1;
    cycles(6);

    // full memory seen from a fresh read pointer
    do_reset();
    DOUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'hC0 + 8'(i));
    cycles(4);
    drain();

    // randomized streaming, many wraps
    for (int c = 0; c < 600; c++) begin
      DOUT_READY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && (wcnt - r_cnt) < 8) write_word(8'($urandom));
      cycles(1);
    end
    drain();

    // empty guard: toggle ready while nothing is available
    for (int c = 0; c < 10; c++) begin
      DOUT_READY = ~DOUT_READY;
      cycles(1);
    end

    // reset in the middle of traffic with a word held in DOUT
    DOUT_READY = 1'b0;
    write_word(8'h5A); write_word(8'h6B); write_word(8'h7C);
    cycles(4);
    check("pre_reset_valid", DOUT_VALID, 1);
    do_reset();
    DOUT_READY = 1'b1;
    write_word(8'h99);
    cycles(3);
    drain();
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-domain controller of the asynchronous FIFO, on the opposite side of the write-pointer path. It receives the Gray-coded write pointer after it has been double-flop synchronized into the read clock domain. From it, the block derives the empty flag and occupancy, generates the memory read address, and publishes its own registered Gray read pointer back toward the write domain. It also drives a first-word-fall-through output register with a valid/ready handshake toward the consuming logic (e.g. UART TX data path).

## Interface
- ADDR_WD, 3, memory address width; depth = 2^ADDR_WD; pointers are ADDR_WD+1 bits
- DATA_WD, 8, data word width
- CLK  input  1  read-domain clock, rising edge
- RST  input  1  asynchronous, active-low reset
- RD_SYNC_WPTR  input  ADDR_WD+1  Gray write pointer, already synchronized into CLK domain
- RD_DATA_MEM  input  DATA_WD  memory read data at RD_ADDR (asynchronous read)
- DOUT_READY  input  1  consumer accepts DOUT this cycle
- RD_ADDR  output  ADDR_WD  memory read address = low ADDR_WD bits of binary read pointer
- RD_GRAY_PTR  output  ADDR_WD+1  registered Gray read pointer, to the write-domain synchronizer
- RD_EMPTY  output  1  registered empty flag
- RD_LEVEL  output  ADDR_WD+1  registered occupancy of memory (excludes word held in DOUT)
- DOUT  output  DATA_WD  output data register
- DOUT_VALID  output  1  DOUT holds a valid word

## Operation
- Reset values: binary pointer rbin=0, RD_ADDR=0, RD_GRAY_PTR=0, RD_EMPTY=1, RD_LEVEL=0, DOUT=0, DOUT_VALID=0.
- Gray encoding: g = b ^ (b >> 1). Gray-to-binary: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
- pop = !RD_EMPTY && (!DOUT_VALID || DOUT_READY).
- On pop: DOUT<=RD_DATA_MEM, DOUT_VALID<=1, rbin<=rbin+1 (mod 2^(ADDR_WD+1)), RD_GRAY_PTR<=gray(rbin+1).
- No pop and DOUT_VALID && DOUT_READY: DOUT_VALID<=0 and DOUT holds its value.
- No pop and no handshake: DOUT and DOUT_VALID hold.
- rnext = rbin + pop.
- RD_EMPTY <= (gray(rnext) == RD_SYNC_WPTR).
- RD_LEVEL <= gray2bin(RD_SYNC_WPTR) - rnext, modulo 2^(ADDR_WD+1). RD_LEVEL==0 iff RD_EMPTY.
- RD_GRAY_PTR changes at most one bit per cycle. It is driven directly from a flop with no combinational logic after it.
- The block never pops when RD_EMPTY=1, whatever the state of DOUT_READY.
- Simultaneous pop and consumer handshake: the old word is accepted, the new word is loaded, and DOUT_VALID stays 1 with no bubble.
- Wrap-around: for ADDR_WD=3, rbin goes 15→0, RD_GRAY_PTR goes 4'b1000→4'b0000, and RD_ADDR goes 7→0.
- Full memory seen from the read side: RD_LEVEL = 2^ADDR_WD, with the pointers differing only in the two MSBs of the Gray code.
- Reset mid-operation: all state clears immediately (asynchronously) and the held DOUT word is discarded. The write side must be reset together with this block.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- RD_SYNC_WPTR changes after edge K (FIFO previously empty):
  - RD_EMPTY falls and RD_LEVEL updates at edge K+1.
  - First pop occurs at edge K+2; DOUT_VALID=1 and DOUT valid after K+2.
- The pop at edge N updates RD_ADDR and RD_GRAY_PTR at the same edge N.
- Sustained throughput is one word per cycle while !RD_EMPTY and DOUT_READY=1.
- The freed location becomes visible to the write domain only after its 2-flop synchronizer, i.e. ≥2 write clocks after edge N.

## Test plan
- Reset: assert RST=0 mid-stream with DOUT_VALID=1 → all outputs return to reset values immediately; RD_EMPTY=1, DOUT_VALID=0.
- Single word: RD_SYNC_WPTR 0→4'b0001 after edge K, memory[0]=8'hA5, DOUT_READY=1 → RD_EMPTY=0 and RD_LEVEL=1 at K+1; DOUT=8'hA5, DOUT_VALID=1, RD_GRAY_PTR=4'b0001, RD_EMPTY=1 at K+2; DOUT_VALID=0 at K+3.
- Backpressure: 3 words queued, DOUT_READY=0 → exactly one pop; DOUT holds word0; RD_LEVEL=2. After raising DOUT_READY, words 1 and 2 are delivered on consecutive cycles in order.
- Full: RD_SYNC_WPTR=gray(8) with rbin=0 → RD_LEVEL=8, RD_EMPTY=0. Streaming with READY=1 drains 8 words back-to-back, after which RD_EMPTY=1.
- Wrap: stream 20 words through with ADDR_WD=3 → data is in order; RD_GRAY_PTR sequence passes 4'b1000→4'b0000; at each step the bench checks a one-bit Gray change and RD_ADDR wrap 7→0.
- Empty guard: RD_EMPTY=1 while DOUT_READY toggles for 10 cycles → rbin, RD_ADDR and RD_GRAY_PTR are unchanged and DOUT_VALID stays 0.
